// File: rtl/maxpool3x3_window_ctrl.sv
// Streaming 3x3 window controller for the float max-pool comparator tree:
// line-buffers a raster feature map, emits strided windows and registers the pooled max.
module maxpool3x3_window_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8,
  parameter int unsigned STRIDE     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] Pix_In,
  input  logic                  Pix_Valid,
  output logic                  Pix_Ready,
  output logic [DATA_WIDTH-1:0] Win_Data0,
  output logic [DATA_WIDTH-1:0] Win_Data1,
  output logic [DATA_WIDTH-1:0] Win_Data2,
  output logic [DATA_WIDTH-1:0] Win_Data3,
  output logic [DATA_WIDTH-1:0] Win_Data4,
  output logic [DATA_WIDTH-1:0] Win_Data5,
  output logic [DATA_WIDTH-1:0] Win_Data6,
  output logic [DATA_WIDTH-1:0] Win_Data7,
  output logic [DATA_WIDTH-1:0] Win_Data8,
  output logic                  Win_Valid,
  input  logic [DATA_WIDTH-1:0] Max_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  input  logic                  Out_Ready,
  output logic                  Frame_Done
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] win [9];

  logic advance, accept, last_pix, row_ok, col_ok;

  // The whole pipeline moves only when the output stage can take a new result.
  assign advance   = ~Valid_Out | Out_Ready;
  assign Pix_Ready = (state == RUN) & advance;
  assign accept    = Pix_Valid & Pix_Ready;
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

  // With STRIDE in {1,2} and r>=2, (r-2)%STRIDE==0 reduces to an LSB test.
  assign row_ok = (row >= ROW_W'(2)) && ((STRIDE == 1) || !row[0]);
  assign col_ok = (col >= COL_W'(2)) && ((STRIDE == 1) || !col[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_nxt;
      Frame_Done <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (!Win_Valid && advance) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && Start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // LB0 holds row r-2, LB1 row r-1 at each column; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= Pix_In;
    end
  end

  // Window shift register and registered comparator result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
      Win_Valid <= 1'b0;
      Valid_Out <= 1'b0;
      Data_Out  <= '0;
    end else if (advance) begin
      Win_Valid <= accept && row_ok && col_ok;
      if (accept) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb0[col];
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb1[col];
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= Pix_In;
      end
      Valid_Out <= Win_Valid;
      if (Win_Valid) Data_Out <= Max_In;
    end
  end

  assign Win_Data0 = win[0];
  assign Win_Data1 = win[1];
  assign Win_Data2 = win[2];
  assign Win_Data3 = win[3];
  assign Win_Data4 = win[4];
  assign Win_Data5 = win[5];
  assign Win_Data6 = win[6];
  assign Win_Data7 = win[7];
  assign Win_Data8 = win[8];

endmodule

// File: tb/tb_maxpool3x3_window_ctrl.sv
// Bench for maxpool3x3_window_ctrl: 5x5/stride-2 and 4x4/stride-1 instances checked
// against a window-position model of pooling results, tap contents and handshakes.
module tb_maxpool3x3_window_ctrl;

  logic clk;
  logic rst;
  logic              start     [2];
  logic              pix_valid [2];
  logic              out_ready [2];
  logic [31:0]       pix_in    [2];
  logic              pix_ready [2];
  logic [8:0][31:0]  win       [2];
  logic              win_valid [2];
  logic [31:0]       max_in    [2];
  logic [31:0]       data_out  [2];
  logic              valid_out [2];
  logic              frame_done[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cur      = 0;
  int rmode    = 0;
  logic lat_en = 1'b0;
  int lit_n    = 0;
  logic [31:0] lit [4];
  logic [31:0] frame_pix [64];
  logic [31:0] exp_q [$];
  int nres, nexp, fd_count;

  function automatic int gw(input int d); return (d == 0) ? 5 : 4; endfunction
  function automatic int gh(input int d); return (d == 0) ? 5 : 4; endfunction
  function automatic int gs(input int d); return (d == 0) ? 2 : 1; endfunction

  // Total order of non-NaN IEEE singles as unsigned keys.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction
  function automatic logic fgt(input logic [31:0] a, input logic [31:0] b);
    return fkey(a) > fkey(b);
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int m;
    int msb;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    msb = 0;
    for (int i = 0; i < 31; i++) if (((m >> i) & 1) != 0) msb = i;
    return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + msb), 23'((m << (23 - msb)) & 32'h7f_ffff)};
  endfunction

  function automatic logic [31:0] win_max(input int d, input int rr, input int cc);
    logic [31:0] m;
    m = frame_pix[rr * gw(d) + cc];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (fgt(frame_pix[(rr + i) * gw(d) + cc + j], m)) m = frame_pix[(rr + i) * gw(d) + cc + j];
    return m;
  endfunction

  function automatic logic emit(input int d, input int k);
    int r;
    int c;
    r = k / gw(d);
    c = k % gw(d);
    return (r >= 2) && (c >= 2) && ((r - 2) % gs(d) == 0) && ((c - 2) % gs(d) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned GW = (g == 0) ? 5 : 4;
    localparam int unsigned GS = (g == 0) ? 2 : 1;
    logic [31:0] m;

    // Stand-in for the combinational comparator tree.
    always_comb begin
      m = win[g][0];
      for (int i = 1; i < 9; i++) if (fgt(win[g][i], m)) m = win[g][i];
    end
    assign max_in[g] = m;

    maxpool3x3_window_ctrl #(
      .DATA_WIDTH(32), .IMG_W(GW), .IMG_H(GW), .STRIDE(GS)
    ) u_dut (
      .clk(clk), .rst(rst), .Start(start[g]),
      .Pix_In(pix_in[g]), .Pix_Valid(pix_valid[g]), .Pix_Ready(pix_ready[g]),
      .Win_Data0(win[g][0]), .Win_Data1(win[g][1]), .Win_Data2(win[g][2]),
      .Win_Data3(win[g][3]), .Win_Data4(win[g][4]), .Win_Data5(win[g][5]),
      .Win_Data6(win[g][6]), .Win_Data7(win[g][7]), .Win_Data8(win[g][8]),
      .Win_Valid(win_valid[g]), .Max_In(max_in[g]),
      .Data_Out(data_out[g]), .Valid_Out(valid_out[g]), .Out_Ready(out_ready[g]),
      .Frame_Done(frame_done[g])
    );
  end

  // Downstream ready: always, random, or a 10-cycle stall on the first result.
  initial begin : rdy_drv
    int stall_cnt;
    logic stall_done;
    stall_cnt = 0;
    stall_done = 1'b0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode != 2) stall_done = 1'b0;
      case (rmode)
        0: out_ready[cur] = 1'b1;
        1: out_ready[cur] = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stall_done && valid_out[cur]) begin
            stall_done = 1'b1;
            stall_cnt = 10;
          end
          if (stall_cnt > 0) begin
            out_ready[cur] = 1'b0;
            stall_cnt--;
          end else begin
            out_ready[cur] = 1'b1;
          end
        end
      endcase
    end
  end

  // Per-cycle checker against the window-position model.
  initial begin : compare
    logic p_acc, p_adv, p_wv, p_hold, acc, ewv, active, vo_seen;
    logic [31:0] p_data, e;
    int p_k, acc_cnt, c_acc12, d, r, c;
    p_acc = 1'b0; p_adv = 1'b1; p_wv = 1'b0; p_hold = 1'b0; active = 1'b0; vo_seen = 1'b0;
    p_data = '0; p_k = 0; acc_cnt = 0; c_acc12 = 0;
    nres = 0; nexp = 0; fd_count = 0;
    forever begin
      @(negedge clk);
      d = cur;
      if (!rst) begin
        p_acc = 1'b0; p_adv = 1'b1; p_wv = 1'b0; p_hold = 1'b0; active = 1'b0;
        exp_q.delete();
      end else begin
        if (start[d] && !active) begin
          exp_q.delete();
          for (int rr = 0; rr + 2 < gh(d); rr += gs(d))
            for (int cc = 0; cc + 2 < gw(d); cc += gs(d))
              exp_q.push_back(win_max(d, rr, cc));
          nexp = exp_q.size();
          if (lit_n > 0) begin
            chk("model_count", 32'(nexp), 32'(lit_n));
            for (int i = 0; i < lit_n && i < nexp; i++) chk("model_lit", exp_q[i], lit[i]);
          end
          active = 1'b1; acc_cnt = 0; nres = 0; fd_count = 0; vo_seen = 1'b0;
        end
        ewv = p_acc ? emit(d, p_k) : (p_adv ? 1'b0 : p_wv);
        chk("win_valid", 32'(win_valid[d]), 32'(ewv));
        if (p_acc && ewv) begin
          r = p_k / gw(d);
          c = p_k % gw(d);
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              chk("win_tap", win[d][3 * i + j], frame_pix[(r - 2 + i) * gw(d) + c - 2 + j]);
        end
        if (p_hold) begin
          chk("hold_valid", 32'(valid_out[d]), 32'd1);
          chk("hold_data", data_out[d], p_data);
        end
        if (valid_out[d] && !out_ready[d]) chk("pix_ready_stall", 32'(pix_ready[d]), 32'd0);
        if (valid_out[d] && out_ready[d]) begin
          if (exp_q.size() == 0) chk("result_count", 32'(nres + 1), 32'(nexp));
          else begin
            e = exp_q.pop_front();
            chk("data_out", data_out[d], e);
          end
          nres++;
        end
        if (lat_en && valid_out[d] && !vo_seen) begin
          vo_seen = 1'b1;
          chk("latency", 32'(cyc - c_acc12), 32'd2);
        end
        if (frame_done[d]) begin
          fd_count++;
          chk("done_after_results", 32'(exp_q.size()), 32'd0);
          active = 1'b0;
        end
        acc = pix_valid[d] & pix_ready[d];
        if (acc) begin
          p_k = acc_cnt;
          if (acc_cnt == 12) c_acc12 = cyc;
          acc_cnt++;
        end
        p_acc = acc;
        p_adv = ~valid_out[d] | out_ready[d];
        p_wv = win_valid[d];
        p_hold = valid_out[d] & ~out_ready[d];
        p_data = data_out[d];
      end
    end
  end

  task automatic chk_idle(input int d);
    chk("rst_pix_ready", 32'(pix_ready[d]), 32'd0);
    chk("rst_win_valid", 32'(win_valid[d]), 32'd0);
    chk("rst_valid_out", 32'(valid_out[d]), 32'd0);
    chk("rst_frame_done", 32'(frame_done[d]), 32'd0);
    chk("rst_data_out", data_out[d], 32'd0);
    chk("rst_win8", win[d][8], 32'd0);
  endtask

  task automatic set_lit(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] e);
    lit[0] = a; lit[1] = b; lit[2] = c; lit[3] = e;
    lit_n = 4;
  endtask

  // vmode: 0 valid always, 1 toggling, 2 random (with stray Start pulses).
  task automatic send_frame(input int d, input int vmode, input int n_stop);
    int k;
    int guard;
    logic acc;
    logic tog;
    k = 0; guard = 0; tog = 1'b1;
    pix_in[d] = frame_pix[0];
    pix_valid[d] = 1'b1;
    while (k < n_stop && guard < 2000) begin
      @(negedge clk);
      acc = pix_valid[d] & pix_ready[d];
      @(posedge clk);
      #1;
      guard++;
      if (acc) k++;
      tog = ~tog;
      start[d] = (vmode == 2) && ($urandom_range(0, 15) == 0);
      if (k < n_stop) begin
        pix_valid[d] = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
        pix_in[d] = pix_valid[d] ? frame_pix[k] : $urandom;
      end else begin
        pix_valid[d] = 1'b0;
      end
    end
    start[d] = 1'b0;
    pix_valid[d] = 1'b0;
    if (guard >= 2000) chk("send_timeout", 32'(k), 32'(n_stop));
  endtask

  task automatic run_frame(input int d, input int vmode, input int rm, input logic lat);
    int g;
    cur = d; rmode = rm; lat_en = lat;
    @(posedge clk); #1; start[d] = 1'b1;
    @(posedge clk); #1; start[d] = 1'b0;
    send_frame(d, vmode, gw(d) * gh(d));
    g = 0;
    while (fd_count == 0 && g < 400) begin
      @(posedge clk);
      g++;
    end
    if (g >= 400) chk("frame_done_timeout", 32'(fd_count), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("frame_done_count", 32'(fd_count), 32'd1);
    chk("result_count", 32'(nres), 32'(nexp));
  endtask

  initial begin : main
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; pix_valid[d] = 1'b0; pix_in[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk_idle(d);
    @(posedge clk); #1; rst = 1'b1;

    for (int i = 0; i < 25; i++) frame_pix[i] = i2f(i);
    set_lit(32'h4140_0000, 32'h4160_0000, 32'h41B0_0000, 32'h41C0_0000);
    run_frame(0, 0, 0, 1'b1);

    for (int i = 0; i < 25; i++) frame_pix[i] = i2f(-(i + 1));
    set_lit(32'hBF80_0000, 32'hC040_0000, 32'hC130_0000, 32'hC150_0000);
    run_frame(0, 0, 0, 1'b0);

    for (int i = 0; i < 16; i++) frame_pix[i] = i2f(i);
    set_lit(32'h4120_0000, 32'h4130_0000, 32'h4160_0000, 32'h4170_0000);
    run_frame(1, 0, 0, 1'b0);

    for (int i = 0; i < 25; i++) frame_pix[i] = i2f(i);
    set_lit(32'h4140_0000, 32'h4160_0000, 32'h41B0_0000, 32'h41C0_0000);
    run_frame(0, 0, 2, 1'b0);
    run_frame(0, 1, 0, 1'b0);

    // Abort mid-frame after pixel 13, then a clean all-7.0 frame.
    lit_n = 0; cur = 0; rmode = 0; lat_en = 1'b0;
    @(posedge clk); #1; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    send_frame(0, 0, 14);
    rst = 1'b0;
    #2;
    chk_idle(0);
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 25; i++) frame_pix[i] = 32'h40E0_0000;
    set_lit(32'h40E0_0000, 32'h40E0_0000, 32'h40E0_0000, 32'h40E0_0000);
    run_frame(0, 0, 0, 1'b0);

    lit_n = 0;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 25; i++)
        frame_pix[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
      run_frame(it % 2, 2, 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool3x3_window_ctrl.md
Name: maxpool3x3_window_ctrl

Overview:
- Streaming controller that feeds the 3x3 floating-point max-pooling comparator tree and collects its results.
- Accepts a raster-order feature map one 32-bit IEEE-754 pixel per handshake and buffers two previous rows in line buffers.
- Presents each strided 3x3 window on nine registered outputs with a valid strobe, then registers the comparator's combinational maximum into an output stage with backpressure.
- Sits between the convolution output stream and the next layer's input FIFO.

Parameters:
- DATA_WIDTH, 32, pixel width; IEEE-754 single.
- IMG_W, 8, feature-map width in pixels (≥3).
- IMG_H, 8, feature-map height in pixels (≥3).
- STRIDE, 2, window step in both directions; legal values 1 or 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; begins a frame when in IDLE.
- Pix_In  in  DATA_WIDTH  input pixel.
- Pix_Valid  in  1  Pix_In valid.
- Pix_Ready  out  1  controller accepts Pix_In this cycle.
- Win_Data0..Win_Data8  out  DATA_WIDTH each  window taps to the comparator tree. 0-2 are the top row, 3-5 the middle row, 6-8 the bottom row, each row left→right. Win_Data8 is the newest pixel.
- Win_Valid  out  1  window taps valid; drives the comparator Valid_In.
- Max_In  in  DATA_WIDTH  comparator Data_Out; combinational from the Win_Data taps.
- Data_Out  out  DATA_WIDTH  pooled result.
- Valid_Out  out  1  Data_Out valid.
- Out_Ready  in  1  downstream accepts Data_Out.
- Frame_Done  out  1  one-cycle pulse after the last result of a frame is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE. Row/column counters=0. Window and output registers=0. Win_Valid=0, Valid_Out=0, Pix_Ready=0, Frame_Done=0. Line-buffer contents are don't-care.
- States:
  - IDLE: Pix_Ready=0. Start→RUN and clears counters.
  - RUN: the pipeline accepts pixels. The last pixel of the frame is (row IMG_H-1, col IMG_W-1); after it is accepted → DRAIN.
  - DRAIN: Pix_Ready=0. Waits until Win_Valid=0 and the output stage is empty or being accepted → DONE.
  - DONE: Frame_Done=1 for one cycle → IDLE.
- Start is ignored outside IDLE.
- Stall: advance = !Valid_Out | Out_Ready. Pix_Ready = (state==RUN) & advance. Accept = Pix_Valid & Pix_Ready. While advance=0, all pipeline registers and counters hold.
- On accept at (row r, col c):
  - Shift the 3x3 window columns left and load the new right column {LB0[c], LB1[c], Pix_In}.
  - Write LB0[c]←LB1[c] and LB1[c]←Pix_In.
  - col increments and wraps at IMG_W-1; row increments on the wrap.
- Window emit: at the cycle after an accept where r≥2, c≥2, (r-2)%STRIDE==0 and (c-2)%STRIDE==0, Win_Valid=1. Otherwise Win_Valid=0 after any advancing cycle.
- Output stage: when advance=1 and Win_Valid=1, register Data_Out←Max_In and set Valid_Out=1. Valid_Out clears on Out_Ready unless refilled the same cycle. Data_Out is held stable while Valid_Out=1 and Out_Ready=0.
- Latency: pixel accepted at cycle t → Win_Valid at t+1 → Valid_Out at t+2, with no stalls.
- Results per frame: ((IMG_W-3)/STRIDE+1)*((IMG_H-3)/STRIDE+1), integer division. Trailing rows/columns that do not complete a strided window are consumed but produce no output.
- Gaps on Pix_Valid: counters hold, Win_Valid drops to 0 the next cycle, and no result is lost.
- Simultaneous Out_Ready and a new result: the output register reloads and Valid_Out stays 1.
- Reset mid-frame: aborts immediately to the reset values above. The next frame requires a fresh Start, and no stale result may appear.

Test Plan:
- IMG_W=IMG_H=5, STRIDE=2, pixels = float(index 0..24), Pix_Valid and Out_Ready held high → Data_Out sequence 12.0, 14.0, 22.0, 24.0. First Valid_Out 2 cycles after pixel 12 is accepted. Frame_Done pulses once after 24.0 is accepted.
- Same geometry with pixels = -(index+1) → Data_Out -1.0, -3.0, -11.0, -13.0, confirming the sign-based maximum with negatives.
- IMG_W=IMG_H=4, STRIDE=1, pixels = float(index) → Data_Out 10.0, 11.0, 14.0, 15.0. Exactly 4 Valid_Out beats.
- Test 1 with Out_Ready=0 for 10 cycles after the first Valid_Out → Data_Out held at 12.0, Pix_Ready=0 within 1 cycle, and the full sequence is still delivered with no duplicates.
- Test 1 with Pix_Valid toggling 1/0 every cycle → identical output sequence. Win_Valid is never asserted on a non-accept cycle.
- Assert rst=0 after pixel 13 is accepted, then Start and send a full 5x5 frame of all 7.0 → outputs at reset are 0. The new frame produces exactly four 7.0 results and one Frame_Done.
